// File: rtl/alu_pkg.sv
// ALU control encodings carried in the low nibble of an instruction.
// Every 4-bit value is named so any instruction slice is a legal member.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOT   = 4'h5,
        ALU_SHL   = 4'h6,
        ALU_SHR   = 4'h7,
        ALU_SRA   = 4'h8,
        ALU_ROL   = 4'h9,
        ALU_ROR   = 4'hA,
        ALU_SLT   = 4'hB,
        ALU_SLTU  = 4'hC,
        ALU_PASSA = 4'hD,
        ALU_PASSB = 4'hE,
        ALU_NOP   = 4'hF
    } control_e;

endpackage

// File: rtl/types_pkg.sv
// Shared fetch-side types: PC width, bubble encoding, opcode slice, FSM states.
// Imported by the fetch stage and its skid buffer.
package types_pkg;

    localparam int PC_W = 16;

    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    typedef logic [3:0] opcode_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that decode could not take.
// Clear wins over load; drain empties the entry after its contents are used.
module fetch_skid_buf
    import types_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_pc
);

    logic            r_valid;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc;

    // Capture, drain or discard the single buffered entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= BUBBLE_INSTR;
            r_pc    <= '0;
        end else if (i_clear || i_drain) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and request FSM.
// A stalled ack parks in the skid buffer so no fetched word is lost.
module fetch_stage
    import types_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_ack,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_sys,
    output logic [15:0]        if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output opcode_t            opcode,
    output alu_pkg::control_e  func,
    output logic               halted
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_ifpc;
    logic            r_valid;

    logic            w_ifid_ld;
    logic [15:0]     w_ld_instr;
    logic [PC_W-1:0] w_ld_pc;
    logic            w_bubble;
    logic            w_skid_ld;
    logic            w_skid_drain;
    logic            w_skid_clr;
    logic            w_skid_valid;
    logic [15:0]     w_skid_instr;
    logic [PC_W-1:0] w_skid_pc;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_ld),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clr),
        .i_instr (imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath controls; halt beats redirect beats ack/stall.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ifid_ld    = 1'b0;
        w_ld_instr   = imem_rdata;
        w_ld_pc      = r_pc;
        w_bubble     = 1'b0;
        w_skid_ld    = 1'b0;
        w_skid_drain = 1'b0;
        w_skid_clr   = 1'b0;
        if (r_state == HALTED) begin
            w_state_nxt = HALTED;
        end else if (halt_sys) begin
            w_state_nxt = HALTED;
            w_bubble    = 1'b1;
            w_skid_clr  = 1'b1;
        end else if (redirect) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = redirect_pc;
            w_bubble    = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (imem_ack && !stall) begin
                        w_ifid_ld = 1'b1;
                        w_pc_nxt  = r_pc + PC_STEP;
                    end else if (imem_ack) begin
                        w_skid_ld   = 1'b1;
                        w_state_nxt = HOLD;
                    end else if (!stall) begin
                        w_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall && w_skid_valid) begin
                        w_ifid_ld    = 1'b1;
                        w_ld_instr   = w_skid_instr;
                        w_ld_pc      = w_skid_pc;
                        w_skid_drain = 1'b1;
                        w_pc_nxt     = r_pc + PC_STEP;
                        w_state_nxt  = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    // PC and IF/ID register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= BUBBLE_INSTR;
            r_ifpc  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_ifid_ld) begin
                r_instr <= w_ld_instr;
                r_ifpc  <= w_ld_pc;
                r_valid <= 1'b1;
            end else if (w_bubble) begin
                r_instr <= BUBBLE_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifpc;
    assign if_id_valid = r_valid;
    assign opcode      = opcode_t'(r_instr[15:12]);
    assign func        = alu_pkg::control_e'(r_instr[3:0]);
    assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_stage;
    import types_pkg::*;

    logic              clk;
    logic              rst;
    logic              imem_req;
    logic [15:0]       imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    logic              stall;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic              halt_sys;
    logic [15:0]       if_id_instr;
    logic [15:0]       if_id_pc;
    logic              if_id_valid;
    opcode_t           opcode;
    alu_pkg::control_e func;
    logic              halted;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_sys    (halt_sys),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .opcode      (opcode),
        .func        (func),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        a;
        logic        r;
        logic        h;
        logic [15:0] rd;
        logic [15:0] rp;
        logic        er;
        logic [15:0] ea;
        logic        ev;
        logic [15:0] ep;
        logic [15:0] ei;
        logic        eh;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, a, r, h, input logic [15:0] rd, rp,
                       input logic er, input logic [15:0] ea,
                       input logic ev, input logic [15:0] ep, ei,
                       input logic eh);
        vec_t v;
        v = '{s, a, r, h, rd, rp, er, ea, ev, ep, ei, eh};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic s, a, r, h, input logic [15:0] rd, rp);
        stall       = s;
        imem_ack    = a;
        redirect    = r;
        halt_sys    = h;
        imem_rdata  = rd;
        redirect_pc = rp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, 32'(if_id_instr), 32'h0000);
        chk({tag, "_ifpc"}, 32'(if_id_pc), 32'h0000);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0000);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        rst = 1'b1;
        #2;
        tick();
        rst = 1'b0;
    endtask

    // Reference model state: architectural view of fetch.
    logic [15:0] m_pc;
    logic [31:0] m_skid[$];
    logic        m_halted;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ifpc;

    task automatic m_reset();
        m_pc     = 16'h0000;
        m_skid   = {};
        m_halted = 1'b0;
        m_valid  = 1'b0;
        m_instr  = 16'h0000;
        m_ifpc   = 16'h0000;
    endtask

    task automatic m_bubble();
        m_valid = 1'b0;
        m_instr = 16'h0000;
    endtask

    task automatic m_step(input logic s, a, r, h, input logic [15:0] rd, rp);
        logic [31:0] e;
        if (m_halted) return;
        if (h) begin
            m_halted = 1'b1;
            m_skid   = {};
            m_bubble();
        end else if (r) begin
            m_pc   = rp;
            m_skid = {};
            m_bubble();
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                e       = m_skid.pop_front();
                m_instr = e[31:16];
                m_ifpc  = e[15:0];
                m_valid = 1'b1;
                m_pc    = 16'((32'(m_pc) + 2) % 65536);
            end
        end else if (a && !s) begin
            m_instr = rd;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = 16'((32'(m_pc) + 2) % 65536);
        end else if (a) begin
            m_skid.push_back({rd, m_pc});
        end else if (!s) begin
            m_bubble();
        end
    endtask

    initial begin
        vec_t        v;
        logic [15:0] ei;
        logic        s, a, r, h;
        logic [15:0] rd, rp;
        logic        exp_req;

        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        #2;
        rst_chk("rst0");
        tick();
        rst = 1'b0;

        add(0,1,0,0,16'hA000,16'h0000, 1,16'h0000, 1,16'h0000,16'hA000, 0);
        add(0,1,0,0,16'hA002,16'h0000, 1,16'h0002, 1,16'h0002,16'hA002, 0);
        add(0,1,0,0,16'hA004,16'h0000, 1,16'h0004, 1,16'h0004,16'hA004, 0);
        add(1,1,0,0,16'hA006,16'h0000, 1,16'h0006, 1,16'h0004,16'hA004, 0);
        add(1,0,0,0,16'h0000,16'h0000, 0,16'h0000, 1,16'h0004,16'hA004, 0);
        add(1,0,0,0,16'h0000,16'h0000, 0,16'h0000, 1,16'h0004,16'hA004, 0);
        add(0,0,0,0,16'h0000,16'h0000, 0,16'h0000, 1,16'h0006,16'hA006, 0);
        add(0,0,0,0,16'h0000,16'h0000, 1,16'h0008, 0,16'h0000,16'h0000, 0);
        add(0,1,0,0,16'hA008,16'h0000, 1,16'h0008, 1,16'h0008,16'hA008, 0);
        add(0,1,1,0,16'hA00A,16'h0040, 1,16'h000A, 0,16'h0000,16'h0000, 0);
        add(0,1,0,0,16'hB041,16'h0000, 1,16'h0040, 1,16'h0040,16'hB041, 0);
        add(0,0,1,0,16'h0000,16'hFFFE, 1,16'h0042, 0,16'h0000,16'h0000, 0);
        add(0,1,0,0,16'h7FFE,16'h0000, 1,16'hFFFE, 1,16'hFFFE,16'h7FFE, 0);
        add(0,1,0,0,16'hC00C,16'h0000, 1,16'h0000, 1,16'h0000,16'hC00C, 0);
        add(0,1,1,1,16'hD002,16'h1234, 1,16'h0002, 0,16'h0000,16'h0000, 1);
        add(0,1,1,0,16'hE000,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 1);
        add(1,1,0,0,16'hE001,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.s, v.a, v.r, v.h, v.rd, v.rp);
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(v.er));
            if (v.er)
                chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(v.ea));
            tick();
            ei = v.ei;
            chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(v.ev));
            chk($sformatf("v%0d_instr", i), 32'(if_id_instr), 32'(ei));
            chk($sformatf("v%0d_opc", i), 32'(opcode), 32'(ei[15:12]));
            chk($sformatf("v%0d_func", i), 32'(func), 32'(ei[3:0]));
            if (v.ev)
                chk($sformatf("v%0d_ifpc", i), 32'(if_id_pc), 32'(v.ep));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v.eh));
        end

        // Reset asserted while holding a stalled word.
        do_reset();
        drive(1, 1, 0, 0, 16'h9999, 16'h0);
        tick();
        chk("hold_req", 32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        rst_chk("rst_hold");
        tick();
        rst = 1'b0;
        drive(0, 1, 0, 0, 16'h1111, 16'h0);
        #1;
        chk("post_hold_addr", 32'(imem_addr), 32'h0000);
        tick();
        chk("post_hold_ifpc", 32'(if_id_pc), 32'h0000);
        chk("post_hold_instr", 32'(if_id_instr), 32'h1111);

        // Reset asserted while halted.
        drive(0, 1, 0, 1, 16'h2222, 16'h0);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        rst_chk("rst_halt");
        tick();
        rst = 1'b0;
        drive(0, 1, 0, 0, 16'h3333, 16'h0);
        #1;
        chk("post_halt_addr", 32'(imem_addr), 32'h0000);
        tick();
        chk("post_halt_instr", 32'(if_id_instr), 32'h3333);

        // Randomized traffic against the reference model.
        do_reset();
        m_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                drive(0, 0, 0, 0, 16'h0, 16'h0);
                rst = 1'b1;
                #1;
                m_reset();
                rst_chk("rnd_rst");
                tick();
                rst = 1'b0;
            end
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 11) == 0);
            h  = ($urandom_range(0, 299) == 0);
            rd = 16'($urandom);
            rp = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom);
            drive(s, a, r, h, rd, rp);
            #1;
            exp_req = !m_halted && (m_skid.size() == 0);
            chk("rnd_req", 32'(imem_req), 32'(exp_req));
            if (exp_req)
                chk("rnd_addr", 32'(imem_addr), 32'(m_pc));
            m_step(s, a, r, h, rd, rp);
            tick();
            chk("rnd_valid", 32'(if_id_valid), 32'(m_valid));
            chk("rnd_instr", 32'(if_id_instr), 32'(m_instr));
            if (m_valid)
                chk("rnd_ifpc", 32'(if_id_pc), 32'(m_ifpc));
            chk("rnd_halted", 32'(halted), 32'(m_halted));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
